// File: rtl/mux_4to1_sync.sv
// mux_4to1_sync
// Registered 4-to-1 selector. The select code {s1,s0} picks one of four
// equal-width sources. On an enabled edge the chosen source is captured
// into y and y_valid is raised for one cycle. With en low, y holds and
// y_valid drops. Asynchronous active-low reset clears both outputs.
//
// Handshake: y_valid is a plain qualifier with no backpressure. It is high
// exactly in the cycle after an edge that saw en=1, and y is meaningful
// whenever y_valid is high. A new selection can be taken on every clock.
module mux_4to1_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             valid_d;
    logic             valid_q;

    assign sel = {s1, s0};

    // Pure decode of the select code. Only the chosen source reaches
    // mux_out, so unknowns on the other sources cannot leak into y.
    always_comb begin
        mux_out = '0;
        case (sel)
            2'b00:   mux_out = i0;
            2'b01:   mux_out = i1;
            2'b10:   mux_out = i2;
            2'b11:   mux_out = i3;
            default: mux_out = '0;
        endcase
    end

    // Next state: capture the selected source when enabled, otherwise hold.
    always_comb begin
        y_d     = y_q;
        valid_d = en;
        if (en) begin
            y_d = mux_out;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;

endmodule

// File: tb/tb_mux_4to1_sync.sv
// Bench for mux_4to1_sync. An 8-bit instance is checked against a
// behavioural model on every cycle, and a 1-bit instance covers the
// exhaustive single-bit sweep. Directed scenarios pin literal values.
module tb_mux_4to1_sync;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic       en = 1'b0;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;
    logic [7:0] i0 = '0;
    logic [7:0] i1 = '0;
    logic [7:0] i2 = '0;
    logic [7:0] i3 = '0;

    logic [7:0] y8;
    logic       v8;
    logic [0:0] y1;
    logic       v1;

    mux_4to1_sync #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .s0(s0), .s1(s1), .y(y8), .y_valid(v8)
    );

    mux_4to1_sync #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i0(i0[0:0]), .i1(i1[0:0]), .i2(i2[0:0]), .i3(i3[0:0]),
        .s0(s0), .s1(s1), .y(y1), .y_valid(v1)
    );

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected y/valid for the 8-bit instance: an array of the four sources
    // indexed by the select number, sampled at each rising edge.
    logic [7:0] srcs [4];
    always_comb begin
        srcs[0] = i0;
        srcs[1] = i1;
        srcs[2] = i2;
        srcs[3] = i3;
    end

    logic [7:0] model_y;
    logic       model_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_y <= 8'h00;
            model_v <= 1'b0;
        end else begin
            model_v <= en;
            if (en) model_y <= srcs[2 * int'(s1) + int'(s0)];
        end
    end

    // ---------------- per-cycle compare ----------------
    logic check_on = 1'b0;
    always @(negedge clk) begin
        if (check_on) begin
            check("model_y", {56'd0, y8}, {56'd0, model_y});
            check("model_v", {63'd0, v8}, {63'd0, model_v});
            check("y_known", {63'd0, $isunknown(y8)}, 64'd0);
        end
    end

    // ---------------- driver ----------------
    // Apply inputs just after a falling edge, then advance to the next
    // falling edge (one rising edge in between captures them).
    task automatic cyc(input logic e, input logic [1:0] sel,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
        en = e; s1 = sel[1]; s0 = sel[0];
        i0 = a; i1 = b; i2 = c; i3 = d;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] pat;
        logic [7:0] r;

        // reset state, clock running, inputs active but ignored
        en = 1'b1; i0 = 8'hFF; i1 = 8'hFF; i2 = 8'hFF; i3 = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_y", {56'd0, y8}, 64'h0);
        check("rst_v", {63'd0, v8}, 64'h0);
        check("rst_y1", {63'd0, y1}, 64'h0);
        rst_n = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check_on = 1'b1;

        // 1. exhaustive single-bit sweep
        for (int p = 0; p < 16; p++) begin
            for (int s = 0; s < 4; s++) begin
                pat = 4'(p);
                r = 8'($urandom);
                i0 = {r[7:1], pat[0]};
                r = 8'($urandom);
                i1 = {r[7:1], pat[1]};
                r = 8'($urandom);
                i2 = {r[7:1], pat[2]};
                r = 8'($urandom);
                i3 = {r[7:1], pat[3]};
                cyc(1'b1, 2'(s), i0, i1, i2, i3);
                check("sweep_y1", {63'd0, y1}, {63'd0, pat[s]});
                check("sweep_v1", {63'd0, v1}, 64'd1);
            end
        end
        // pinned example: pattern 0100, select 10 -> 1
        cyc(1'b1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00);
        check("sweep_ex", {63'd0, y1}, 64'd1);

        // 2. enable hold
        cyc(1'b1, 2'b10, 8'h00, 8'h00, 8'hA5, 8'h00);
        check("hold_cap", {56'd0, y8}, 64'hA5);
        cyc(1'b0, 2'b10, 8'h00, 8'h00, 8'hA5, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check("hold_y", {56'd0, y8}, 64'hA5);
            check("hold_v", {63'd0, v8}, 64'd0);
            cyc(1'b0, 2'b00, 8'h77, 8'h00, 8'h3C, 8'h00);
        end
        cyc(1'b1, 2'b00, 8'h77, 8'h00, 8'h3C, 8'h00);
        check("hold_resume", {56'd0, y8}, 64'h77);

        // 3. async reset mid-stream
        cyc(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
        check("pre_rst", {56'd0, y8}, 64'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_y", {56'd0, y8}, 64'h00);
        check("async_v", {63'd0, v8}, 64'd0);
        @(negedge clk);
        check("rst_hold_y", {56'd0, y8}, 64'h00);
        en = 1'b1; s1 = 1'b0; s0 = 1'b1; i1 = 8'h12;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_y", {56'd0, y8}, 64'h12);
        check("post_rst_v", {63'd0, v8}, 64'd1);

        // 4. back-to-back select/data changes
        cyc(1'b1, 2'b00, 8'h11, 8'h00, 8'h00, 8'h00);
        check("b2b_0", {56'd0, y8}, 64'h11);
        cyc(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h44);
        check("b2b_1", {56'd0, y8}, 64'h44);
        cyc(1'b1, 2'b01, 8'h00, 8'h22, 8'h00, 8'h00);
        check("b2b_2", {56'd0, y8}, 64'h22);

        // 5. unselected inputs unknown
        cyc(1'b1, 2'b11, 8'hxx, 8'hxx, 8'hxx, 8'h5A);
        check("xiso_y", {56'd0, y8}, 64'h5A);
        check("xiso_known", {63'd0, $isunknown(y8)}, 64'd0);

        // randomized traffic with occasional mid-cycle resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
